// File: rtl/sd_block_buffer.sv
// ============================================================================
// sd_block_buffer
// ----------------------------------------------------------------------------
// Captures the SD-controller byte stream into one of NUM_BANKS block buffers
// (ping-pong when NUM_BANKS == 2). Completed blocks are exposed to the CPU bus
// as a read-only window. Every read strobe gets a one-cycle-latency result.
//
// Optional feature (macro SD_BUF_WORD_READ_EN):
//   defined   - reads return the 8 bytes of the aligned 64-bit word that holds
//               bus_offset_i, little-endian. bus_offset_i[2:0] is ignored.
//               Storage is organised as 64-bit words with byte-lane writes.
//   undefined - reads return one byte, zero-extended to 64 bits. Storage is
//               byte-wide.
//
// Ports:
//   clk_i               system clock
//   reset_i             synchronous, active-high reset
//   fill_start_i        one-cycle pulse that arms capture of the next block
//   fill_byte_i[7:0]    byte from the SD controller
//   fill_valid_i        byte-available level; a byte is captured on its rising edge
//   release_i           one-cycle pulse: the CPU is done with the current read bank
//   bus_read_enable_i   address-qualified read strobe
//   bus_offset_i        byte offset within the block
//   bus_read_data_o     read result; holds its value between reads
//   bus_read_done_o     one-cycle pulse marking bus_read_data_o valid
//   block_available_o   the read bank holds a complete block
//   fill_busy_o         capture in progress
//   fill_count_o        bytes captured in the current fill
//   overrun_o           sticky error flag, cleared only by reset
// ============================================================================
module sd_block_buffer #(
    parameter int BLOCK_BYTES = 512,
    parameter int NUM_BANKS   = 2,
    parameter int OFF_W       = 12
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             fill_start_i,
    input  logic [7:0]       fill_byte_i,
    input  logic             fill_valid_i,
    input  logic             release_i,
    input  logic             bus_read_enable_i,
    input  logic [OFF_W-1:0] bus_offset_i,
    output logic [63:0]      bus_read_data_o,
    output logic             bus_read_done_o,
    output logic             block_available_o,
    output logic             fill_busy_o,
    output logic [OFF_W:0]   fill_count_o,
    output logic             overrun_o
);

    localparam int OFS_W     = $clog2(BLOCK_BYTES);
    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BANK_W    = (NUM_BANKS > 1) ? BANK_BITS : 1;
    localparam int AW        = OFS_W + BANK_BITS;
    localparam int DEPTH     = NUM_BANKS * BLOCK_BYTES;

    localparam logic [OFF_W:0] LAST_IDX  = (OFF_W+1)'(BLOCK_BYTES - 1);
    localparam logic [OFF_W:0] BLOCK_LEN = (OFF_W+1)'(BLOCK_BYTES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_e;

    // Bank indices wrap modulo NUM_BANKS. NUM_BANKS is a power of two, so the
    // natural wrap of the counter does this, except for the single-bank case.
    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        if (NUM_BANKS == 1) return '0;
        else                return b + 1'b1;
    endfunction

    state_e                 state_q, state_d;
    logic [BANK_W-1:0]      wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0]      rd_bank_q, rd_bank_d;
    logic [NUM_BANKS-1:0]   full_q, full_d;
    logic [OFF_W:0]         fill_count_q, fill_count_d;
    logic                   overrun_q, overrun_d;
    logic                   fv_q;
    logic [63:0]            rd_data_q;
    logic                   rd_done_q;

    logic                   capture_ev;
    logic                   wr_en;
    logic                   last_byte;
    logic                   rd_hit;
    logic [AW-1:0]          wr_addr;
    logic [AW-1:0]          rd_addr;
    logic [63:0]            rd_raw;

    // A byte is captured once per rising edge of the byte-available level,
    // however long the level stays high.
    assign capture_ev = fill_valid_i & ~fv_q;
    assign wr_en      = (state_q == S_FILL) & capture_ev;
    assign last_byte  = wr_en & (fill_count_q == LAST_IDX);

    // Storage address is {bank, offset}. With one bank the bank field is empty.
    assign wr_addr = (AW'(wr_bank_q) << OFS_W) | AW'(fill_count_q[OFS_W-1:0]);
    assign rd_addr = (AW'(rd_bank_q) << OFS_W) | AW'(bus_offset_i[OFS_W-1:0]);

    // Offsets past the end of the block read as zero. Compare the full offset
    // so that high bits are not aliased back into the block.
    assign rd_hit = full_q[rd_bank_q] & ({1'b0, bus_offset_i} < BLOCK_LEN);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            wr_bank_q    <= '0;
            rd_bank_q    <= '0;
            full_q       <= '0;
            fill_count_q <= '0;
            overrun_q    <= 1'b0;
            fv_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            full_q       <= full_d;
            fill_count_q <= fill_count_d;
            overrun_q    <= overrun_d;
            fv_q         <= fill_valid_i;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default first,
    // so that no path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (fill_start_i && !full_q[wr_bank_q]) state_d = S_FILL;
            S_FILL: if (last_byte)                          state_d = S_IDLE;
            default:                                        state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: bank bookkeeping, fill counter, overrun flag.
    always_comb begin
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        full_d       = full_q;
        fill_count_d = fill_count_q;
        overrun_d    = overrun_q;

        if (state_q == S_IDLE) begin
            if (fill_start_i) begin
                if (full_q[wr_bank_q]) overrun_d    = 1'b1;
                else                   fill_count_d = '0;
            end
            // A byte with nowhere to go is dropped and flagged.
            if (capture_ev) overrun_d = 1'b1;
        end

        if (wr_en) fill_count_d = fill_count_q + 1'b1;

        if (release_i && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = next_bank(rd_bank_q);
        end

        // Applied after the release so that, when both hit the same bank,
        // the bank ends up full.
        if (last_byte) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = next_bank(wr_bank_q);
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        fill_busy_o       = (state_q == S_FILL);
        block_available_o = full_q[rd_bank_q];
    end

    assign fill_count_o    = fill_count_q;
    assign overrun_o       = overrun_q;
    assign bus_read_data_o = rd_data_q;
    assign bus_read_done_o = rd_done_q;

    // ------------------------------------------------------------------------
    // Block storage: one write port (fill) and one read port (bus)
    // ------------------------------------------------------------------------
`ifdef SD_BUF_WORD_READ_EN
    logic [63:0] mem_q [DEPTH/8];

    // NOTE: the storage array has no reset; its contents are undefined until
    // written, which keeps it mappable onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_addr[AW-1:3]][{wr_addr[2:0], 3'b000} +: 8] <= fill_byte_i;
    end

    assign rd_raw = mem_q[rd_addr[AW-1:3]];
`else
    logic [7:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; its contents are undefined until
    // written, which keeps it mappable onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_addr] <= fill_byte_i;
    end

    assign rd_raw = {56'd0, mem_q[rd_addr]};
`endif

    // Read result register: updated only on a strobe, otherwise holds.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_q <= '0;
            rd_done_q <= 1'b0;
        end else begin
            rd_done_q <= bus_read_enable_i;
            if (bus_read_enable_i) rd_data_q <= rd_hit ? rd_raw : 64'd0;
        end
    end

endmodule

// File: tb/tb_sd_block_buffer.sv
// ============================================================================
// tb_sd_block_buffer
// ----------------------------------------------------------------------------
// Directed bench for sd_block_buffer with default parameters
// (BLOCK_BYTES=512, NUM_BANKS=2, OFF_W=12). Inputs are driven and outputs are
// sampled 1 ns after each rising clock edge. Expected read data follow
// SD_BUF_WORD_READ_EN when it is defined.
// ============================================================================
module tb_sd_block_buffer;

    localparam int OFF_W = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic             fill_start;
    logic [7:0]       fill_byte;
    logic             fill_valid;
    logic             release_p;
    logic             bus_read_enable;
    logic [OFF_W-1:0] bus_offset;
    logic [63:0]      bus_read_data;
    logic             bus_read_done;
    logic             block_available;
    logic             fill_busy;
    logic [OFF_W:0]   fill_count;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    sd_block_buffer #(
        .BLOCK_BYTES(512),
        .NUM_BANKS  (2),
        .OFF_W      (OFF_W)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .fill_start_i     (fill_start),
        .fill_byte_i      (fill_byte),
        .fill_valid_i     (fill_valid),
        .release_i        (release_p),
        .bus_read_enable_i(bus_read_enable),
        .bus_offset_i     (bus_offset),
        .bus_read_data_o  (bus_read_data),
        .bus_read_done_o  (bus_read_done),
        .block_available_o(block_available),
        .fill_busy_o      (fill_busy),
        .fill_count_o     (fill_count),
        .overrun_o        (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected read value for a block filled with byte i = i[7:0] ^ key.
    function automatic logic [63:0] exp_pat(input int off, input logic [7:0] key);
        logic [63:0] w;
        logic [OFF_W-1:0] o;
        logic [OFF_W-1:0] a;
        w = '0;
        o = OFF_W'(off);
`ifdef SD_BUF_WORD_READ_EN
        for (int k = 0; k < 8; k++) begin
            a = {o[OFF_W-1:3], 3'b000} + OFF_W'(k);
            w[8*k +: 8] = a[7:0] ^ key;
        end
`else
        a = o;
        w[7:0] = a[7:0] ^ key;
`endif
        return w;
    endfunction

    // Expected read value for a block filled with one constant byte.
    function automatic logic [63:0] exp_const(input logic [7:0] b);
`ifdef SD_BUF_WORD_READ_EN
        return {8{b}};
`else
        return {56'd0, b};
`endif
    endfunction

    task automatic send_byte(input logic [7:0] b);
        fill_byte  = b;
        fill_valid = 1'b1;
        tick();
        fill_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic pulse_release();
        release_p = 1'b1;
        tick();
        release_p = 1'b0;
    endtask

    // Full 512-byte fill: pattern ? i^key : key.
    task automatic fill_block(input logic [7:0] key, input bit pattern);
        logic [7:0] b;
        pulse_start();
        for (int i = 0; i < 512; i++) begin
            b = i[7:0];
            send_byte(pattern ? (b ^ key) : key);
        end
    endtask

    // Single read: done and data one cycle after the strobe, then done drops
    // while data holds.
    task automatic do_read(input string tag, input int off, input logic [63:0] exp);
        bus_offset      = OFF_W'(off);
        bus_read_enable = 1'b1;
        tick();
        bus_read_enable = 1'b0;
        chk({tag, "_done"}, {63'd0, bus_read_done}, 64'd1);
        chk({tag, "_data"}, bus_read_data, exp);
        tick();
        chk({tag, "_done_drop"}, {63'd0, bus_read_done}, 64'd0);
        chk({tag, "_hold"}, bus_read_data, exp);
    endtask

    initial begin
        reset           = 1'b1;
        fill_start      = 1'b0;
        fill_byte       = 8'h00;
        fill_valid      = 1'b0;
        release_p       = 1'b0;
        bus_read_enable = 1'b0;
        bus_offset      = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_avail",   {63'd0, block_available}, 64'd0);
        chk("rst_busy",    {63'd0, fill_busy},       64'd0);
        chk("rst_count",   64'(fill_count),          64'd0);
        chk("rst_overrun", {63'd0, overrun},         64'd0);
        chk("rst_done",    {63'd0, bus_read_done},   64'd0);
        chk("rst_data",    bus_read_data,            64'd0);

        // First fill, byte i = i[7:0]
        pulse_start();
        chk("start_busy",  {63'd0, fill_busy}, 64'd1);
        chk("start_count", 64'(fill_count),    64'd0);

        // fill_valid held high for 5 cycles counts once
        fill_byte  = 8'h00;
        fill_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        fill_valid = 1'b0;
        tick();
        chk("hold_level_count", 64'(fill_count), 64'd1);

        for (int i = 1; i < 512; i++) begin
            if (i == 256) begin
                // fill_start during FILL is ignored without flagging
                pulse_start();
                chk("start_in_fill_count",   64'(fill_count),  64'd256);
                chk("start_in_fill_overrun", {63'd0, overrun}, 64'd0);
            end
            send_byte(8'(i));
        end
        chk("fill1_avail",   {63'd0, block_available}, 64'd1);
        chk("fill1_busy",    {63'd0, fill_busy},       64'd0);
        chk("fill1_count",   64'(fill_count),          64'd512);
        chk("fill1_overrun", {63'd0, overrun},         64'd0);

        // Reads of the first block
        do_read("rd_1ff", 'h1FF, exp_pat('h1FF, 8'h00));
`ifdef SD_BUF_WORD_READ_EN
        do_read("rd_00b", 'h00B, 64'h0F0E_0D0C_0B0A_0908);
`else
        do_read("rd_00b", 'h00B, 64'h0000_0000_0000_000B);
`endif
        do_read("rd_000", 0,   exp_pat(0, 8'h00));
        do_read("rd_600", 600, 64'd0);

        // Back-to-back strobes give back-to-back done pulses
        bus_offset      = OFF_W'(5);
        bus_read_enable = 1'b1;
        tick();
        chk("b2b_done0", {63'd0, bus_read_done}, 64'd1);
        chk("b2b_data0", bus_read_data, exp_pat(5, 8'h00));
        bus_offset = OFF_W'(13);
        tick();
        bus_read_enable = 1'b0;
        chk("b2b_done1", {63'd0, bus_read_done}, 64'd1);
        chk("b2b_data1", bus_read_data, exp_pat(13, 8'h00));
        tick();
        chk("b2b_done_drop", {63'd0, bus_read_done}, 64'd0);

        // Release bank 0; bank 1 is empty, so nothing is available
        pulse_release();
        chk("rel1_avail", {63'd0, block_available}, 64'd0);
        do_read("rd_empty", 3, 64'd0);
        // Release with nothing available is a no-op
        pulse_release();

        // Ping-pong: A (0xAA) into bank 1, B (0x55) into bank 0
        fill_block(8'hAA, 1'b0);
        chk("fillA_avail", {63'd0, block_available}, 64'd1);
        fill_block(8'h55, 1'b0);
        do_read("rd_A", 7, exp_const(8'hAA));
        pulse_release();
        chk("relA_avail", {63'd0, block_available}, 64'd1);
        do_read("rd_B", 100, exp_const(8'h55));
        pulse_release();
        chk("relB_avail", {63'd0, block_available}, 64'd0);
        do_read("rd_after_rel", 100, 64'd0);
        chk("pp_overrun", {63'd0, overrun}, 64'd0);

        // Both banks full, then fill_start -> overrun, stay IDLE
        fill_block(8'h11, 1'b0);
        fill_block(8'h22, 1'b0);
        chk("both_full_overrun", {63'd0, overrun}, 64'd0);
        pulse_start();
        chk("ovr_start_flag", {63'd0, overrun},   64'd1);
        chk("ovr_start_busy", {63'd0, fill_busy}, 64'd0);
        send_byte(8'h99);
        chk("ovr_idle_busy", {63'd0, fill_busy}, 64'd0);
        do_read("rd_C", 0, exp_const(8'h11));
        pulse_release();
        do_read("rd_D", 3, exp_const(8'h22));
        chk("ovr_sticky", {63'd0, overrun}, 64'd1);

        // Reset in the middle of a fill
        pulse_start();
        for (int i = 0; i < 100; i++) send_byte(8'(i));
        chk("mid_count", 64'(fill_count),    64'd100);
        chk("mid_busy",  {63'd0, fill_busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_busy",    {63'd0, fill_busy},       64'd0);
        chk("mrst_count",   64'(fill_count),          64'd0);
        chk("mrst_avail",   {63'd0, block_available}, 64'd0);
        chk("mrst_overrun", {63'd0, overrun},         64'd0);

        // Fresh fill after reset completes normally
        fill_block(8'h3C, 1'b1);
        chk("fill2_avail", {63'd0, block_available}, 64'd1);
        chk("fill2_count", 64'(fill_count),          64'd512);
        chk("fill2_busy",  {63'd0, fill_busy},       64'd0);
        do_read("rd2_010", 'h010, exp_pat('h010, 8'h3C));
        do_read("rd2_1ff", 'h1FF, exp_pat('h1FF, 8'h3C));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
